// File: rtl/boreal_ledger_arb.sv
// Round-robin arbiter for the single BOREAL ledger append port.
// Assigns ledger indices, mirrors the ledger index and halts on exhaustion or divergence.
module boreal_ledger_arb #(
  parameter int          N_REQ   = 4,
  parameter int          DATA_W  = 64,
  parameter logic [31:0] MAX_IDX = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      pause,
  output logic                      led_wr_en,
  output logic [DATA_W-1:0]         led_wr_data,
  input  logic [31:0]               led_idx,
  output logic                      cmp_valid,
  output logic [2:0]                cmp_src,
  output logic [31:0]               cmp_idx,
  output logic                      full,
  output logic                      err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_SYNC, S_RUN, S_FULL, S_ERROR} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [31:0]        shadow_q, shadow_d;
  logic               wr_en_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [2:0]         src_q;
  logic [31:0]        idx_q;

  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_id;
  logic [PTR_W-1:0]   scan;
  logic               hs;
  logic [32:0]        led_view;
  logic               mismatch;

  // Stage 0: rotating priority scan starting at the round-robin pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = PTR_W'((int'(rr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_id    = scan;
      end
    end
  end

  assign hs = (state_q == S_RUN) && !pause && gnt_found;

  // The ledger only counts a write one edge after the strobe, so a pending write is added back in.
  assign led_view = {1'b0, led_idx} + {32'b0, wr_en_q};
  assign mismatch = (led_view != {1'b0, shadow_q});

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    rr_d      = rr_q;
    req_ready = '0;
    unique case (state_q)
      S_SYNC: begin
        shadow_d = led_idx;
        state_d  = (led_idx == MAX_IDX) ? S_FULL : S_RUN;
      end
      S_RUN: begin
        if (hs) begin
          req_ready[gnt_id] = 1'b1;
          shadow_d          = shadow_q + 32'd1;
          rr_d              = (gnt_id == PTR_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        if (mismatch) begin
          state_d = S_ERROR;
        end else if (hs && (shadow_d == MAX_IDX)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (mismatch) state_d = S_ERROR;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Stage 1: registered ledger write and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SYNC;
      rr_q      <= '0;
      shadow_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      src_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      shadow_q <= shadow_d;
      wr_en_q  <= hs;
      if (hs) begin
        wr_data_q <= req_data[gnt_id*DATA_W +: DATA_W];
        src_q     <= 3'(gnt_id);
        idx_q     <= shadow_q;
      end
    end
  end

  assign led_wr_en   = wr_en_q;
  assign led_wr_data = wr_data_q;
  assign cmp_valid   = wr_en_q;
  assign cmp_src     = src_q;
  assign cmp_idx     = idx_q;
  assign full        = (state_q == S_FULL);
  assign err         = (state_q == S_ERROR);

endmodule

// File: tb/tb_boreal_ledger_arb.sv
// Scoreboard bench for boreal_ledger_arb with a behavioural ledger and arbiter reference model.
module tb_boreal_ledger_arb;

  localparam int          N    = 4;
  localparam int          DW   = 64;
  localparam logic [31:0] MAXI = 32'd40;

  localparam int MS_SYNC = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_FULL = 2;
  localparam int MS_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              pause = 1'b0;
  logic              led_wr_en;
  logic [DW-1:0]     led_wr_data;
  logic [31:0]       led_idx;
  logic              cmp_valid;
  logic [2:0]        cmp_src;
  logic [31:0]       cmp_idx;
  logic              full;
  logic              err;

  always #5 clk = ~clk;

  boreal_ledger_arb #(.N_REQ(N), .DATA_W(DW), .MAX_IDX(MAXI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .pause       (pause),
    .led_wr_en   (led_wr_en),
    .led_wr_data (led_wr_data),
    .led_idx     (led_idx),
    .cmp_valid   (cmp_valid),
    .cmp_src     (cmp_src),
    .cmp_idx     (cmp_idx),
    .full        (full),
    .err         (err)
  );

  // Ledger: counts strobed writes; skip_at lets a test make it miss one increment.
  logic [31:0] led_start = 32'd0;
  logic [31:0] skip_at   = 32'hFFFF_FFFF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_idx <= led_start;
    else if (led_wr_en && (led_idx != skip_at)) led_idx <= led_idx + 32'd1;
  end

  typedef struct {
    logic [2:0]    src;
    logic [31:0]   idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_err = 0;
  int            m_mode = MS_SYNC;
  int            m_ptr = 0;
  logic [31:0]   m_shadow = '0;
  bit            m_pend = 1'b0;
  bit [N-1:0]    pend = '0;
  logic [DW-1:0] pdata [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: raise new requests, drive, then predict and check this cycle's grant.
  task automatic step(input logic [N-1:0] newreq, input bit p);
    int win;
    int j;
    logic [N-1:0] exp_rdy;
    bit mism;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (newreq[i] && !pend[i]) begin
        pend[i]  = 1'b1;
        pdata[i] = {$urandom(), $urandom()};
      end
      req_valid[i]          = pend[i];
      req_data[i*DW +: DW]  = pdata[i];
    end
    pause = p;
    #1;
    win = -1;
    exp_rdy = '0;
    mism = 1'b0;
    if (m_mode == MS_RUN && !p) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && pend[j]) win = j;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("full", full, m_mode == MS_FULL);
    chk("err", err, m_mode == MS_ERR);
    if (m_mode == MS_SYNC) begin
      m_shadow = led_start;
      m_mode   = (led_start == MAXI) ? MS_FULL : MS_RUN;
      m_pend   = 1'b0;
    end else begin
      // ledger must hold every entry written so far except the one on the strobe right now
      if (m_mode == MS_RUN || m_mode == MS_FULL)
        mism = (led_idx != m_shadow - 32'(m_pend));
      m_pend = 1'b0;
      if (win >= 0) begin
        q.push_back('{src: 3'(win), idx: m_shadow, data: pdata[win]});
        m_shadow = m_shadow + 32'd1;
        m_ptr    = (win + 1) % N;
        pend[win] = 1'b0;
        m_pend   = 1'b1;
      end
      if (mism) m_mode = MS_ERR;
      else if (win >= 0 && m_shadow == MAXI) m_mode = MS_FULL;
    end
  endtask

  task automatic do_reset(input logic [31:0] start, input bit expect_wr);
    @(posedge clk);
    #1;
    if (expect_wr) chk("wr_en_before_reset", led_wr_en, 1'b1);
    led_start = start;
    rst_n = 1'b0;
    q.delete();
    m_mode = MS_SYNC;
    m_ptr = 0;
    m_shadow = '0;
    m_pend = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_led_wr_en", led_wr_en, 1'b0);
    chk("rst_cmp_valid", cmp_valid, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_led_wr_data", led_wr_data, '0);
    chk("rst_cmp_src", cmp_src, '0);
    chk("rst_cmp_idx", cmp_idx, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Monitor: sampled shortly after each rising edge, pops one expectation per completion.
  initial begin : monitor
    exp_t e;
    bit want;
    forever begin
      @(posedge clk);
      #2;
      want = (q.size() > 0);
      chk("cmp_valid", cmp_valid, want);
      chk("led_wr_en", led_wr_en, want);
      if (want) begin
        e = q.pop_front();
        chk("cmp_src", cmp_src, e.src);
        chk("cmp_idx", cmp_idx, e.idx);
        chk("led_wr_data", led_wr_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < N; i++) pdata[i] = '0;

    // all requesters continuously valid
    do_reset(32'd0, 1'b0);
    repeat (9) step(4'hF, 1'b0);
    pend = '0;
    repeat (2) step('0, 1'b0);

    // single requester, then pointer-driven choice
    do_reset(32'd0, 1'b0);
    step('0, 1'b0);
    pdata[2] = 64'hA5;
    pend[2]  = 1'b1;
    step('0, 1'b0);
    step(4'b1001, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);

    // pause with a write in flight
    step(4'b0010, 1'b0);
    repeat (5) step(4'b0011, 1'b1);
    repeat (3) step('0, 1'b0);

    // random traffic, runs into index exhaustion
    repeat (150) step(N'($urandom()), ($urandom_range(0, 9) == 0));
    pend = '0;
    do_reset(32'd0, 1'b0);
    repeat (60) step(N'($urandom()), ($urandom_range(0, 4) == 0));

    // ledger misses an increment
    pend = '0;
    do_reset(32'd0, 1'b0);
    skip_at = 32'd5;
    repeat (14) step(4'hF, 1'b0);
    skip_at = 32'hFFFF_FFFF;

    // three indices left before exhaustion
    pend = '0;
    do_reset(MAXI - 32'd3, 1'b0);
    repeat (8) step(4'b0010, 1'b0);

    // ledger already at the limit
    pend = '0;
    do_reset(MAXI, 1'b0);
    repeat (4) step(4'hF, 1'b0);

    // reset while a write is on the strobe
    pend = '0;
    do_reset(32'd0, 1'b0);
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    do_reset(32'd0, 1'b1);
    step(4'b0100, 1'b0);
    step('0, 1'b0);
    repeat (2) step('0, 1'b0);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/boreal_ledger_arb.md
Name: boreal_ledger_arb

Overview:
- Round-robin arbiter and sequencer for the single append port of the BOREAL ledger.
- Shares the port among N_REQ requesters and issues at most one ledger write per cycle.
- Returns the ledger index assigned to each accepted entry.
- Keeps a shadow copy of the ledger index, checks it against the ledger every cycle, and stops granting when the index space is exhausted or a mismatch is detected.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 64, width of each entry payload.
- MAX_IDX, 32'hFFFF_FFFF, ledger index value at which no further writes are allowed.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  N_REQ  per-requester append request
- req_data  in  N_REQ*DATA_W  per-requester payload; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot grant, combinational
- pause  in  1  suppresses new grants; an in-flight write still completes
- led_wr_en  out  1  ledger write strobe, registered
- led_wr_data  out  DATA_W  payload for the ledger, registered
- led_idx  in  32  current ledger index from boreal_ledger
- cmp_valid  out  1  completion pulse, coincident with led_wr_en
- cmp_src  out  3  requester id of the completion
- cmp_idx  out  32  ledger index assigned to the entry
- full  out  1  index space exhausted
- err  out  1  sticky shadow/ledger mismatch

Behaviour:
- Reset values:
  - led_wr_en, cmp_valid, full, err = 0.
  - led_wr_data, cmp_src, cmp_idx = 0.
  - shadow_idx = 0; RR pointer = 0; state = SYNC.
- FSM states: SYNC, RUN, FULL, ERROR.
  - SYNC: req_ready = 0. Load shadow_idx <= led_idx. Next state is FULL if led_idx == MAX_IDX, otherwise RUN. Lasts exactly 1 cycle after reset release.
  - RUN: grants are allowed.
  - FULL: full = 1, no grants. Exits only via reset.
  - ERROR: err = 1, no grants. Exits only via reset.
- Grant rule, combinational, in RUN only, when pause = 0:
  - Winner is the first i with req_valid[i] = 1, scanning upward from the RR pointer and wrapping modulo N_REQ.
  - req_ready is one-hot on the winner; all-zero if no request.
  - A handshake occurs when req_valid[i] && req_ready[i].
- Handshake at cycle T produces, at cycle T+1 (registered):
  - led_wr_en = 1, led_wr_data = req_data[i];
  - cmp_valid = 1, cmp_src = i, cmp_idx = shadow_idx as of T.
- Also at the T→T+1 edge:
  - shadow_idx <= shadow_idx + 1;
  - RR pointer <= (i + 1) mod N_REQ.
- Back-to-back handshakes are allowed every cycle; latency is 1 cycle; throughput is 1 entry/cycle.
- Pointer and shadow_idx hold when there is no handshake.
- Consistency check, in RUN and FULL: every cycle after SYNC, led_idx must equal shadow_idx.
  - The ledger increments on the same edge that samples led_wr_en, so led_idx is observed = old + 1 at T+2.
  - On mismatch: err <= 1, state <= ERROR. A write already registered (led_wr_en at T+1) still completes.
- Full handling:
  - When a handshake makes shadow_idx reach MAX_IDX, go to FULL on the same edge; full = 1 from T+1.
  - The last assigned index is MAX_IDX-1. shadow_idx never wraps.
- Pause:
  - Takes effect combinationally on req_ready in the same cycle.
  - Does not cancel a write already registered.
  - Does not move the RR pointer.
- Requester obligations:
  - req_data must be stable while req_valid = 1.
  - A requester must not drop req_valid before it is granted. This is not checked; the arbiter simply re-arbitrates.
- Reset mid-operation: all outputs return to reset values asynchronously, and a pending led_wr_en is dropped. The ledger resets in the same domain, so SYNC re-reads led_idx = 0.
- ERROR takes priority over FULL when both conditions occur on the same edge.

Test Plan:
1. Reset, led_idx = 0. Requesters 0..3 all hold req_valid for 8 cycles.
   -> Grants in order 0,1,2,3,0,1,2,3, one per cycle.
   -> cmp_idx = 0..7; led_wr_en high for 8 consecutive cycles starting one cycle after the first grant.
2. Only requester 2 is valid, with data 0xA5.
   -> req_ready = 4'b0100 the same cycle.
   -> Next cycle: led_wr_en = 1, led_wr_data = 0xA5, cmp_src = 2, cmp_idx = 0.
   -> RR pointer becomes 3; with requesters 0 and 3 then both valid, 3 wins.
3. pause = 1 with requesters 0 and 1 valid for 5 cycles.
   -> req_ready = 0, no led_wr_en.
   -> After pause drops, requester 0 is granted first; a write granted the cycle before pause rose still completes.
4. Ledger model skips an increment (led_idx stays 5 after a write at index 5).
   -> err = 1 and state = ERROR on the next cycle; req_ready = 0 thereafter until reset.
5. MAX_IDX = 3, requester 1 valid continuously.
   -> Exactly 3 grants with cmp_idx = 0,1,2.
   -> full = 1 from the cycle of the third write; no further led_wr_en.
6. Assert rst_n low during a cycle where led_wr_en = 1.
   -> All outputs are 0 immediately.
   -> After release: 1 SYNC cycle with req_ready = 0, then grants resume at cmp_idx = 0.
